syndrome_calc: RTL and testbench

SYNDROME_CALC -- requirements
Module: syndrome_calc

---
 rtl/syndrome_calc_if.sv | 34 +++
 rtl/syndrome_calc.sv | 148 ++++++++++++++
 tb/tb_syndrome_calc.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/syndrome_calc_if.sv
// Input bit stream and syndrome output stream of the BCH syndrome calculator.
// Build macro SYN_ZERO_FLAG_EN adds the syn_zero (error-free frame) flag.
// Both streams use valid/ready handshakes; the slave modport is the calculator side.
interface syndrome_calc_if;
    logic        in_valid;
    logic        in_bit;
    logic        in_last;
    logic        in_ready;
    logic        syn_valid;
    logic        syn_ready;
    logic [12:0] syn_data;
    logic [4:0]  syn_idx;
    logic        syn_last;
    logic        frame_err;
`ifdef SYN_ZERO_FLAG_EN
    logic        syn_zero;
`endif

    modport master (
        output in_valid, in_bit, in_last, syn_ready,
        input  in_ready, syn_valid, syn_data, syn_idx, syn_last, frame_err
`ifdef SYN_ZERO_FLAG_EN
        , input syn_zero
`endif
    );

    modport slave (
        input  in_valid, in_bit, in_last, syn_ready,
        output in_ready, syn_valid, syn_data, syn_idx, syn_last, frame_err
`ifdef SYN_ZERO_FLAG_EN
        , output syn_zero
`endif
    );
endinterface

// File: rtl/syndrome_calc.sv
// BCH syndrome calculator: Horner accumulation of 2T syndromes over GF(2^13), then serial emission.
// Latency: one bit per cycle in ACC; S_1 valid the cycle after the in_last transfer. Macro SYN_ZERO_FLAG_EN adds syn_zero.
// Backpressure: in_ready low during OUT; each syndrome held until syn_valid&&syn_ready.
module syndrome_calc #(
    parameter int N = 8191,
    parameter int T = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    syndrome_calc_if.slave bus
);
    localparam int NS = 2 * T;
    localparam int CW = $clog2(N + 1);
    localparam int IW = $clog2(NS + 1);

    typedef enum logic {ST_ACC, ST_OUT} state_t;

    // Multiply by alpha^p: p repeated shifts reduced by x^13+x^4+x^3+x+1 (p is a constant per lane).
    function automatic logic [12:0] gf_mul_apow(input logic [12:0] a, input int p);
        logic [12:0] r;
        r = a;
        for (int k = 0; k < p; k++) begin
            r = {r[11:0], 1'b0} ^ (r[12] ? 13'h001B : 13'h0000);
        end
        return r;
    endfunction

    state_t        r_state;
    state_t        w_state_nxt;
    logic [12:0]   r_syn [1:NS];
    logic [12:0]   w_syn_nxt [1:NS];
    logic [CW-1:0] r_cnt;
    logic          r_err;
    logic [IW-1:0] r_idx;
    logic [12:0]   w_sel;
    logic          w_in_ready;
    logic          w_syn_valid;
    logic          w_xfer;
    logic          w_cnt_full;
    logic          w_ignore;
    logic          w_hs;
    logic          w_done;
    logic [CW:0]   w_cnt_incl;

    assign w_xfer     = bus.in_valid && w_in_ready;
    assign w_cnt_full = (r_cnt == CW'(N));
    // Bits beyond N without in_last cannot belong to a valid codeword: drop them, flag the frame.
    assign w_ignore   = w_xfer && w_cnt_full && !bus.in_last;
    assign w_hs       = w_syn_valid && bus.syn_ready;
    assign w_done     = w_hs && (r_idx == IW'(NS));
    assign w_cnt_incl = {1'b0, r_cnt} + {{CW{1'b0}}, 1'b1};

    // One Horner step per lane: S_j * alpha^j + r_i.
    for (genvar j = 1; j <= NS; j++) begin : g_lane
        assign w_syn_nxt[j] = gf_mul_apow(r_syn[j], j) ^ {12'b0, bus.in_bit};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_ACC;
        else        r_state <= w_state_nxt;
    end

    // Next state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_syn_valid = 1'b0;
        case (r_state)
            ST_ACC: begin
                w_in_ready = 1'b1;
                if (bus.in_valid && bus.in_last) w_state_nxt = ST_OUT;
            end
            ST_OUT: begin
                w_syn_valid = 1'b1;
                if (w_done) w_state_nxt = ST_ACC;
            end
            default: w_state_nxt = ST_ACC;
        endcase
    end

    // Select the syndrome addressed by the output index.
    always_comb begin
        w_sel = 13'h0000;
        for (int j = 1; j <= NS; j++) begin
            if (r_idx == IW'(j)) w_sel = r_syn[j];
        end
    end

`ifdef SYN_ZERO_FLAG_EN
    logic r_zero;
    logic w_nxt_nonzero;

    // Any nonzero syndrome after the final Horner step means the frame holds errors.
    always_comb begin
        w_nxt_nonzero = 1'b0;
        for (int j = 1; j <= NS; j++) begin
            w_nxt_nonzero = w_nxt_nonzero | (|w_syn_nxt[j]);
        end
    end

    // Latch the zero flag at frame end; clear it when the last syndrome leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      r_zero <= 1'b0;
        else if (w_xfer && bus.in_last)  r_zero <= !w_nxt_nonzero;
        else if (w_done)                 r_zero <= 1'b0;
    end

    assign bus.syn_zero = w_syn_valid && r_zero;
`endif

    // Accumulate syndromes/length in ACC; step the output index in OUT and clear for the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 1; j <= NS; j++) r_syn[j] <= 13'h0000;
            r_cnt <= '0;
            r_err <= 1'b0;
            r_idx <= '0;
        end else if (w_xfer) begin
            if (w_ignore) begin
                r_err <= 1'b1;
            end else begin
                for (int j = 1; j <= NS; j++) r_syn[j] <= w_syn_nxt[j];
                if (!w_cnt_full) r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
            end
            if (bus.in_last) begin
                r_err <= r_err || (w_cnt_incl != (CW+1)'(N));
                r_idx <= IW'(1);
            end
        end else if (w_hs) begin
            if (w_done) begin
                for (int j = 1; j <= NS; j++) r_syn[j] <= 13'h0000;
                r_cnt <= '0;
                r_err <= 1'b0;
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + {{(IW-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.syn_valid = w_syn_valid;
    assign bus.syn_data  = w_syn_valid ? w_sel : 13'h0000;
    assign bus.syn_idx   = 5'(r_idx);
    assign bus.syn_last  = w_syn_valid && (r_idx == IW'(NS));
    assign bus.frame_err = w_syn_valid && r_err;
endmodule

// File: tb/tb_syndrome_calc.sv
// Directed bench for syndrome_calc with N=8191, T=4 and hand-computed GF(2^13) syndromes.
// Frames: all-zero, r[0], r[1] with output stall, r[2] (reduction), short, overlong, mid-frame reset.
// Outputs are sampled on the falling edge; inputs are driven on the falling edge.
module tb_syndrome_calc;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    logic [12:0] exp_syn [1:8];

    syndrome_calc_if ifc ();

    syndrome_calc #(.N(8191), .T(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_exp(input logic [12:0] a, b, c, d, e, f, g, h);
        exp_syn[1] = a; exp_syn[2] = b; exp_syn[3] = c; exp_syn[4] = d;
        exp_syn[5] = e; exp_syn[6] = f; exp_syn[7] = g; exp_syn[8] = h;
    endtask

    // Stream nbits bits; bit at position one_pos (0 = first = r[N-1]) is 1, others 0.
    task automatic send_frame(input int nbits, input int one_pos, input bit with_last);
        int g;
        for (int p = 0; p < nbits; p++) begin
            @(negedge clk);
            ifc.in_valid = 1'b1;
            ifc.in_bit   = (p == one_pos);
            ifc.in_last  = with_last && (p == nbits - 1);
            g = 0;
            while (!ifc.in_ready && g < 20) begin
                @(negedge clk);
                g++;
            end
            if (g == 20) check("in_ready_timeout", 32'(ifc.in_ready), 32'd1);
            @(posedge clk);
        end
        @(negedge clk);
        ifc.in_valid = 1'b0;
        ifc.in_bit   = 1'b0;
        ifc.in_last  = 1'b0;
        if (with_last) begin
            check("latency_valid", 32'(ifc.syn_valid), 32'd1);
            check("latency_idx", 32'(ifc.syn_idx), 32'd1);
        end
    endtask

    // Consume the 8 syndromes, optionally stalling 5 cycles on index stall_j.
    task automatic collect(input logic exp_err, input logic exp_zero, input int stall_j);
        int g;
        ifc.syn_ready = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            g = 0;
            while (!ifc.syn_valid && g < 50) begin
                @(negedge clk);
                g++;
            end
            check($sformatf("valid_j%0d", j), 32'(ifc.syn_valid), 32'd1);
            check($sformatf("idx_j%0d", j), 32'(ifc.syn_idx), 32'(j));
            check($sformatf("data_j%0d", j), 32'(ifc.syn_data), 32'(exp_syn[j]));
            check($sformatf("last_j%0d", j), 32'(ifc.syn_last), 32'(j == 8));
            check($sformatf("err_j%0d", j), 32'(ifc.frame_err), 32'(exp_err));
            check($sformatf("in_ready_out_j%0d", j), 32'(ifc.in_ready), 32'd0);
`ifdef SYN_ZERO_FLAG_EN
            check($sformatf("zero_j%0d", j), 32'(ifc.syn_zero), 32'(exp_zero));
`else
            if (exp_zero === 1'bx) checks = checks;
`endif
            if (j == stall_j) begin
                ifc.syn_ready = 1'b0;
                ifc.in_valid  = 1'b1;
                ifc.in_bit    = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("stall_valid", 32'(ifc.syn_valid), 32'd1);
                    check("stall_idx", 32'(ifc.syn_idx), 32'(j));
                    check("stall_data", 32'(ifc.syn_data), 32'(exp_syn[j]));
                    check("stall_in_ready", 32'(ifc.in_ready), 32'd0);
                end
                ifc.in_valid  = 1'b0;
                ifc.in_bit    = 1'b0;
                ifc.syn_ready = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
        end
        check("back_acc_valid", 32'(ifc.syn_valid), 32'd0);
        check("back_acc_ready", 32'(ifc.in_ready), 32'd1);
    endtask

    initial begin
        int seen;
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.in_bit    = 1'b0;
        ifc.in_last   = 1'b0;
        ifc.syn_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(ifc.syn_valid), 32'd0);
        check("rst_data", 32'(ifc.syn_data), 32'd0);
        check("rst_idx", 32'(ifc.syn_idx), 32'd0);
        check("rst_last", 32'(ifc.syn_last), 32'd0);
        check("rst_err", 32'(ifc.frame_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(ifc.in_ready), 32'd1);

        // All-zero codeword.
        set_exp(13'h0, 13'h0, 13'h0, 13'h0, 13'h0, 13'h0, 13'h0, 13'h0);
        send_frame(8191, -1, 1'b1);
        collect(1'b0, 1'b1, 0);

        // Only r[0] set: every S_j = 1.
        set_exp(13'h1, 13'h1, 13'h1, 13'h1, 13'h1, 13'h1, 13'h1, 13'h1);
        send_frame(8191, 8190, 1'b1);
        collect(1'b0, 1'b0, 0);

        // Only r[1] set: S_j = alpha^j; stall on S_3 with junk input during OUT.
        set_exp(13'h0002, 13'h0004, 13'h0008, 13'h0010, 13'h0020, 13'h0040, 13'h0080, 13'h0100);
        send_frame(8191, 8189, 1'b1);
        collect(1'b0, 1'b0, 3);

        // Only r[2] set: S_j = alpha^2j; alpha^14 = 0x36, alpha^16 = 0xD8 exercise reduction.
        set_exp(13'h0004, 13'h0010, 13'h0040, 13'h0100, 13'h0400, 13'h1000, 13'h0036, 13'h00D8);
        send_frame(8191, 8188, 1'b1);
        collect(1'b0, 1'b0, 0);

        // Short frame of 100 bits with last bit 1: length error, S_j = 1.
        set_exp(13'h1, 13'h1, 13'h1, 13'h1, 13'h1, 13'h1, 13'h1, 13'h1);
        send_frame(100, 99, 1'b1);
        collect(1'b1, 1'b0, 0);

        // Following full frame is clean again.
        set_exp(13'h0, 13'h0, 13'h0, 13'h0, 13'h0, 13'h0, 13'h0, 13'h0);
        send_frame(8191, -1, 1'b1);
        collect(1'b0, 1'b1, 0);

        // Overlong frame: the 8192nd bit (a 1) is dropped, last bit 0, length error.
        send_frame(8193, 8191, 1'b1);
        collect(1'b1, 1'b1, 0);

        // Reset after 4000 bits discards the frame; no syndromes appear.
        send_frame(4000, 17, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_valid", 32'(ifc.syn_valid), 32'd0);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ifc.syn_valid) seen++;
        end
        check("midrst_no_output", 32'(seen), 32'd0);
        check("midrst_in_ready", 32'(ifc.in_ready), 32'd1);
        send_frame(8191, -1, 1'b1);
        collect(1'b0, 1'b1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
